// File: rtl/serializer_pkg.sv
// Shared types and constants for the word serializer.
// The state encoding is common to the FSM and any debug or monitoring logic.
package serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // $clog2 that never collapses to a zero-width vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Divisor counter for the serializer: counts 0..Divisor-1 while enabled and
// pulses tick on the last count so the caller can advance one bit period.
module bit_timer
  import serializer_pkg::*;
#(
  parameter int unsigned Divisor = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned DivW = clog2_min1(Divisor);

  logic [DivW-1:0] cnt_q;

  assign tick = en && (cnt_q == DivW'(Divisor - 1));

  // Held at zero while idle so every bit period starts from a clean count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DivW'(1);
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: captures a word over valid/ready and sends
// start, data, even parity and stop bits, each held for Divisor clocks.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned BitNo    = 7,
  parameter int unsigned Divisor  = 1,
  parameter bit          LsbFirst = 1'b1
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [BitNo:0] In,
  input  logic           InValid,
  output logic           InReady,
  output logic           SerOut,
  output logic           Busy
);

  localparam int unsigned NBits = BitNo + 1;
  localparam int unsigned CntW  = clog2_min1(NBits);

  ser_state_t     state_q;
  logic [BitNo:0] shreg_q;
  logic           parity_q;
  logic [CntW-1:0] idx_q;

  logic            tick;
  logic            transfer;
  logic            last_bit;
  logic [CntW-1:0] idx_nxt;
  logic [CntW-1:0] sel_idx;
  logic [CntW-1:0] pos;
  logic            bit_sel;

  assign transfer = InValid && InReady;
  assign last_bit = (idx_q == CntW'(NBits - 1));

  bit_timer #(
    .Divisor(Divisor)
  ) u_bit_timer (
    .clk (Clock),
    .rst (Reset),
    .en  (state_q != IDLE),
    .tick(tick)
  );

  // Level for the bit that the next period will carry: bit 0 when leaving
  // START, otherwise the bit after the current one.
  always_comb begin
    idx_nxt = last_bit ? '0 : idx_q + CntW'(1);
    sel_idx = (state_q == START) ? '0 : idx_nxt;
    pos     = LsbFirst ? sel_idx : CntW'(BitNo) - sel_idx;
    bit_sel = shreg_q[pos];
  end

  // Outputs are computed from the next state so they line up with it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      idx_q    <= '0;
      SerOut   <= IDLE_LEVEL;
      InReady  <= 1'b1;
      Busy     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (transfer) begin
            shreg_q  <= In;
            parity_q <= ^In;
            idx_q    <= '0;
            state_q  <= START;
            SerOut   <= ~IDLE_LEVEL;
            InReady  <= 1'b0;
            Busy     <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            SerOut  <= bit_sel;
          end
        end
        DATA: begin
          if (tick) begin
            idx_q <= idx_nxt;
            if (last_bit) begin
              state_q <= PARITY;
              SerOut  <= parity_q;
            end else begin
              SerOut <= bit_sel;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            SerOut  <= IDLE_LEVEL;
          end
        end
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            SerOut  <= IDLE_LEVEL;
            InReady <= 1'b1;
            Busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          SerOut  <= IDLE_LEVEL;
          InReady <= 1'b1;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: three configurations checked cycle by cycle
// against frames built from the word, bit order, parity and divisor.
module tb_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  in_a, in_b;
  logic [15:0] in_c;
  logic        v_a, v_b, v_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        ser_a, ser_b, ser_c;
  logic        busy_a, busy_b, busy_c;

  int total = 0;
  int bad   = 0;

  word_serializer #(.BitNo(7), .Divisor(1), .LsbFirst(1'b1)) dut_a (
    .Clock(clk), .Reset(rst), .In(in_a), .InValid(v_a),
    .InReady(rdy_a), .SerOut(ser_a), .Busy(busy_a)
  );

  word_serializer #(.BitNo(7), .Divisor(4), .LsbFirst(1'b0)) dut_b (
    .Clock(clk), .Reset(rst), .In(in_b), .InValid(v_b),
    .InReady(rdy_b), .SerOut(ser_b), .Busy(busy_b)
  );

  word_serializer #(.BitNo(15), .Divisor(1), .LsbFirst(1'b1)) dut_c (
    .Clock(clk), .Reset(rst), .In(in_c), .InValid(v_c),
    .InReady(rdy_c), .SerOut(ser_c), .Busy(busy_c)
  );

  function automatic int nbits(input int d);
    return (d == 2) ? 16 : 8;
  endfunction

  function automatic int div(input int d);
    return (d == 1) ? 4 : 1;
  endfunction

  function automatic bit lsb(input int d);
    return (d == 1) ? 1'b0 : 1'b1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic [15:0] w, input logic v);
    case (d)
      0: begin in_a = w[7:0]; v_a = v; end
      1: begin in_b = w[7:0]; v_b = v; end
      default: begin in_c = w; v_c = v; end
    endcase
  endtask

  task automatic sample(input int d, output logic s, output logic b, output logic r);
    case (d)
      0: begin s = ser_a; b = busy_a; r = rdy_a; end
      1: begin s = ser_b; b = busy_b; r = rdy_b; end
      default: begin s = ser_c; b = busy_c; r = rdy_c; end
    endcase
  endtask

  task automatic check_idle(input int d, input string tag);
    logic s, b, r;
    sample(d, s, b, r);
    check({tag, " ser"}, s, 1'b1);
    check({tag, " busy"}, b, 1'b0);
    check({tag, " ready"}, r, 1'b1);
  endtask

  // Called on the negedge of the first start-bit cycle; returns on the
  // negedge just after the stop bit.
  task automatic expect_frame(input int d, input logic [15:0] w, input string tag);
    logic bits[$];
    int   nb = nbits(d);
    int   ones = 0;
    logic s, b, r;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(lsb(d) ? w[i] : w[nb - 1 - i]);
      ones += int'(w[i]);
    end
    bits.push_back(logic'(ones % 2));
    bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < div(d); c++) begin
        sample(d, s, b, r);
        check($sformatf("%s bit%0d.%0d ser", tag, k, c), s, bits[k]);
        check($sformatf("%s bit%0d.%0d busy", tag, k, c), b, 1'b1);
        check($sformatf("%s bit%0d.%0d ready", tag, k, c), r, 1'b0);
        @(negedge clk);
      end
    end
  endtask

  // One-cycle valid pulse, then the input word is scrambled to show it was
  // captured at the handshake.
  task automatic send(input int d, input logic [15:0] w, input string tag);
    logic s, b, r;
    drive(d, w, 1'b1);
    sample(d, s, b, r);
    check({tag, " pre ready"}, r, 1'b1);
    @(negedge clk);
    drive(d, 16'($urandom), 1'b0);
    expect_frame(d, w, tag);
    check_idle(d, {tag, " post"});
  endtask

  initial begin
    logic s, b, r;
    logic [15:0] w;
    int d;

    rst = 1'b1;
    drive(0, 16'h0, 1'b0);
    drive(1, 16'h0, 1'b0);
    drive(2, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      check_idle(0, "rst a");
      check_idle(1, "rst b");
      check_idle(2, "rst c");
      @(negedge clk);
    end

    send(0, 16'h00A5, "a5");
    send(1, 16'h0001, "b01");

    // InValid held across both words; the second waits for InReady.
    drive(0, 16'h003C, 1'b1);
    @(negedge clk);
    drive(0, 16'h00FF, 1'b1);
    expect_frame(0, 16'h003C, "b2b 3c");
    check_idle(0, "b2b gap");
    @(negedge clk);
    drive(0, 16'($urandom), 1'b0);
    expect_frame(0, 16'h00FF, "b2b ff");
    check_idle(0, "b2b end");

    // Abort in data bit 3: start + bits 0..2 have gone by.
    w = 16'($urandom);
    drive(0, w, 1'b1);
    @(negedge clk);
    drive(0, 16'h0, 1'b0);
    repeat (4) @(negedge clk);
    sample(0, s, b, r);
    check("abort bit3 ser", s, w[3]);
    check("abort bit3 busy", b, 1'b1);
    #2 rst = 1'b1;
    #1 check_idle(0, "abort async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle(0, "abort released");
    send(0, 16'h0055, "after abort 55");

    send(2, 16'h8001, "c8001");

    for (int n = 0; n < 8; n++) begin
      d = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) begin
        check_idle(d, "rand gap");
        @(negedge clk);
      end
      send(d, 16'($urandom), $sformatf("rand%0d d%0d", n, d));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Transmit-side counterpart to the parallel bit-vector modules in the parameter examples.
- Accepts a parallel word of BitNo+1 bits through a valid/ready handshake and emits it as an asynchronous-style serial frame: start, data, even parity, stop.
- One bit is emitted every Divisor clocks.
- Sits between a parallel producer and a single-wire link.

Parameters:
- BitNo, 7, MSB index of data word; word width is BitNo+1.
- Divisor, 1, clocks per serial bit (>=1).
- LsbFirst, 1, bit order: 1 = bit 0 first, 0 = bit BitNo first.
- localparam NBits, BitNo+1, data bits per frame.
- localparam CntW, $clog2(NBits) (min 1), width of bit index counter.
- localparam DivW, $clog2(Divisor) (min 1), width of divisor counter.

Ports:
- Clock  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-high.
- In  input  BitNo+1  parallel data word.
- InValid  input  1  In is valid.
- InReady  output  1  block can accept a word this cycle.
- SerOut  output  1  serial line; idles high.
- Busy  output  1  frame in progress.

Behaviour:
- Reset (async assert, sync-released state): state=IDLE, SerOut=1, InReady=1, Busy=0, counters=0, shift register=0.
- Handshake: transfer when InValid && InReady at a rising edge. InReady=1 only in IDLE. In is sampled into the shift register on transfer; later changes to In are ignored.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on transfer. Parity is computed at capture as ^In (even: parity bit makes total ones even).
- Each non-IDLE state holds SerOut for exactly Divisor clocks. The divisor counter runs 0..Divisor-1 and wraps; the state advances on the wrap.
- Outputs per state:
  - START: SerOut=0.
  - DATA: SerOut = current bit. Advance after NBits bits; bit index counter wraps to 0.
  - PARITY: SerOut = parity bit.
  - STOP: SerOut=1, then -> IDLE.
- Registered outputs: SerOut, Busy and InReady are registered. SerOut changes on the edge after the state change, so the first start-bit clock is the cycle after the transfer.
- Frame length: NBits+3 bit periods = (NBits+3)*Divisor clocks from the first start-bit cycle to the end of the stop bit.
- Back-to-back: the block returns to IDLE after the stop bit, so there is at least 1 idle clock (InReady high) between frames. No gap is inserted otherwise.
- Busy=1 in START/DATA/PARITY/STOP, 0 in IDLE.
- InValid while Busy: ignored; the producer must hold the word until InReady.
- Reset mid-frame: immediate abort, SerOut=1. The partial frame is not resumed.
- Divisor=1: each bit lasts exactly 1 clock. The divisor counter is a constant 0 and is legal.

Decomposition:
- Package serializer_pkg holds:
  - typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} ser_state_t;
  - constant IDLE_LEVEL = 1'b1.
- One natural sub-module, bit_timer: a divisor counter with a tick output, parameterized by Divisor, reset asynchronously with Reset.

Test Plan:
- Reset, no stimulus -> SerOut=1, InReady=1, Busy=0 held for 20 clocks.
- BitNo=7, Divisor=1, LsbFirst=1, In=8'hA5 one-cycle valid -> SerOut sequence 0,1,0,1,0,0,1,0,1,0,1. Parity=0 (4 ones). Busy high 11 clocks. InReady returns 1 the cycle after the stop bit.
- Divisor=4, In=8'h01, LsbFirst=0 -> each bit held 4 clocks. Data order is 0,0,0,0,0,0,0,1. Parity=1. Frame spans 44 clocks.
- InValid held high with words 8'h3C then 8'hFF -> two complete frames. Exactly 1 idle clock between them. The second word is accepted only when InReady=1, and its parity bit is 0.
- Reset asserted during DATA bit 3 -> SerOut=1 and InReady=1 immediately (asynchronously). A new word 8'h55 then transmits a clean full frame.
- BitNo=15, Divisor=1, In=16'h8001, LsbFirst=1 -> 19-bit frame: 0, 1, fourteen 0s, 1, parity 0, 1.
